// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl: serialises a parallel word MSB-first onto the run-length
// detector's X input and accumulates saturating Y1/Y2 hit counts, sampling
// each detector result a fixed latency after the bit that produced it.
module fsm_seq_ctrl #(
   parameter int   WORD_W   = 16,
   parameter int   CNT_W    = 8,
   parameter int   DET_LAT  = 1,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              clr_cnt,
   output logic              x_out,
   input  logic              y1_in,
   input  logic              y2_in,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  y1_cnt,
   output logic [CNT_W-1:0]  y2_cnt
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int BCW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int DCW = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;
   localparam logic [BCW-1:0]   LAST_BIT = BCW'(WORD_W - 1);
   localparam logic [DCW-1:0]   LAST_DRN = DCW'(DET_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [1:0]        state;
   logic [WORD_W-1:0] shreg;     // bits still to be driven, next one at MSB
   logic [BCW-1:0]    bit_cnt;   // index of the bit currently on x_out
   logic [DCW-1:0]    drn_cnt;
   logic [DET_LAT:0]  vld_pipe;  // [0] = x_out carries a word bit
   logic              load;
   logic              sample;

   assign in_ready = (state == S_IDLE);
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);
   assign load     = in_valid && in_ready;
   // Result of a driven bit is valid DET_LAT edges after the detector captured it.
   assign sample   = vld_pipe[DET_LAT];

   // Sequencer FSM and serial datapath
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         drn_cnt <= '0;
         x_out   <= IDLE_BIT;
      end else begin
         case (state)
            S_IDLE: begin
               x_out <= IDLE_BIT;
               if (load) begin
                  x_out   <= in_data[WORD_W-1];
                  shreg   <= {in_data[WORD_W-2:0], 1'b0};
                  bit_cnt <= '0;
                  state   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (bit_cnt == LAST_BIT) begin
                  x_out   <= IDLE_BIT;
                  drn_cnt <= '0;
                  state   <= S_DRAIN;
               end else begin
                  x_out   <= shreg[WORD_W-1];
                  shreg   <= {shreg[WORD_W-2:0], 1'b0};
                  bit_cnt <= bit_cnt + BCW'(1);
               end
            end
            S_DRAIN: begin
               x_out <= IDLE_BIT;
               if (drn_cnt == LAST_DRN) state <= S_DONE;
               else                     drn_cnt <= drn_cnt + DCW'(1);
            end
            default: begin
               x_out <= IDLE_BIT;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Valid pipe tracking which cycles carry real word bits (never idle/drain)
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0]         <= load || ((state == S_SHIFT) && (bit_cnt != LAST_BIT));
         vld_pipe[DET_LAT:1] <= vld_pipe[DET_LAT-1:0];
      end
   end

   // Saturating hit counters; clear beats a same-cycle increment
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         y1_cnt <= '0;
         y2_cnt <= '0;
      end else if (clr_cnt) begin
         y1_cnt <= '0;
         y2_cnt <= '0;
      end else if (sample) begin
         if (y1_in && (y1_cnt != CNT_MAX)) y1_cnt <= y1_cnt + CNT_W'(1);
         if (y2_in && (y2_cnt != CNT_MAX)) y2_cnt <= y2_cnt + CNT_W'(1);
      end
   end

endmodule
